mprj_checkpoint_monitor: RTL

- Synthesisable checkpoint-sequence monitor for user-project bring-up and self-test.
- Watches a CHECK_W-bit status field, normally the GPIO checkbits a firmware image drives.
- Requires NUM_CHECKS programmed codes to appear in order, each stable for STABLE_CYCLES, with a per-step timeout.
- Reports pass/fail/timeout, the current step and elapsed cycles, so firmware or a logic analyser can read the verdict without a simulator.

---
 rtl/mprj_checkpoint_monitor_if.sv | 27 ++
 rtl/mprj_checkpoint_monitor.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/mprj_checkpoint_monitor_if.sv
// Control and status bundle for the checkpoint monitor.
// The master side (firmware or bench) drives start/abort/check; the slave side is the monitor.
interface mprj_checkpoint_monitor_if #(
  parameter int unsigned CHECK_W = 16,
  parameter int unsigned STEP_W  = 2
);
  logic               start_i;
  logic               abort_i;
  logic [CHECK_W-1:0] check_i;
  logic               busy_o;
  logic               pass_o;
  logic               fail_o;
  logic               timeout_o;
  logic [STEP_W-1:0]  step_o;
  logic [31:0]        cycles_o;
  logic [CHECK_W-1:0] last_o;

  modport master (
    output start_i, abort_i, check_i,
    input  busy_o, pass_o, fail_o, timeout_o, step_o, cycles_o, last_o
  );

  modport slave (
    input  start_i, abort_i, check_i,
    output busy_o, pass_o, fail_o, timeout_o, step_o, cycles_o, last_o
  );
endinterface

// File: rtl/mprj_checkpoint_monitor.sv
// Checkpoint-sequence monitor: expects NUM_CHECKS codes in order on check_i, each held stable,
// with a per-step timeout, and reports a sticky pass/fail verdict with registered status.
module mprj_checkpoint_monitor #(
  parameter int unsigned                   CHECK_W        = 16,
  parameter int unsigned                   NUM_CHECKS     = 2,
  parameter logic [NUM_CHECKS*CHECK_W-1:0] CODES          = {16'hAB61, 16'hAB60},
  parameter int unsigned                   TIMEOUT_CYCLES = 30000,
  parameter int unsigned                   STABLE_CYCLES  = 2,
  parameter bit                            STRICT         = 1'b0
) (
  input logic                      wb_clk_i,
  input logic                      wb_rst_i,
  mprj_checkpoint_monitor_if.slave mon_io
);
  localparam int unsigned STEP_W = $clog2(NUM_CHECKS + 1);
  localparam int unsigned MW     = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned TW     = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StArmed, StPass, StFail} state_e;

  state_e             state_q, state_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [31:0]        cycles_q, cycles_d;
  logic [MW-1:0]      match_q, match_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic               busy_q, busy_d;
  logic               pass_q, pass_d;
  logic               fail_q, fail_d;
  logic               timeout_q, timeout_d;
  logic [CHECK_W-1:0] last_q, last_d;

  logic [CHECK_W-1:0] target;
  logic               hit, ahead, accept;

  always_comb begin
    target = '0;
    ahead  = 1'b0;
    for (int k = 0; k < NUM_CHECKS; k++) begin
      if (step_q == STEP_W'(k)) target = CODES[k*CHECK_W +: CHECK_W];
      // Only later codes count as out-of-order; earlier ones may legitimately linger.
      if (STRICT && (k > int'(step_q)) && (mon_io.check_i == CODES[k*CHECK_W +: CHECK_W])) begin
        ahead = 1'b1;
      end
    end
    hit    = (mon_io.check_i == target);
    accept = hit && (match_q == MW'(STABLE_CYCLES - 1));
  end

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    cycles_d  = cycles_q;
    match_d   = match_q;
    timer_d   = timer_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    timeout_d = timeout_q;
    last_d    = last_q;

    unique case (state_q)
      StArmed: begin
        if (cycles_q != 32'hFFFF_FFFF) cycles_d = cycles_q + 32'd1;
        if (accept) begin
          step_d  = step_q + 1'b1;
          match_d = '0;
          timer_d = '0;
          if (step_q == STEP_W'(NUM_CHECKS - 1)) begin
            state_d = StPass;
            pass_d  = 1'b1;
          end
        end else begin
          match_d = hit ? match_q + 1'b1 : '0;
          timer_d = timer_q + 1'b1;
          if (timer_q == TW'(TIMEOUT_CYCLES - 2)) begin
            state_d   = StFail;
            fail_d    = 1'b1;
            timeout_d = 1'b1;
            last_d    = mon_io.check_i;
          end else if (ahead) begin
            state_d = StFail;
            fail_d  = 1'b1;
            last_d  = mon_io.check_i;
          end
        end
      end
      StIdle, StPass, StFail: ;
      default: state_d = StIdle;
    endcase

    if (mon_io.start_i && (state_q != StArmed)) begin
      state_d   = StArmed;
      step_d    = '0;
      cycles_d  = '0;
      match_d   = '0;
      timer_d   = '0;
      pass_d    = 1'b0;
      fail_d    = 1'b0;
      timeout_d = 1'b0;
      last_d    = '0;
    end

    if (mon_io.abort_i) begin
      state_d   = StIdle;
      step_d    = '0;
      cycles_d  = '0;
      match_d   = '0;
      timer_d   = '0;
      pass_d    = 1'b0;
      fail_d    = 1'b0;
      timeout_d = 1'b0;
      last_d    = '0;
    end

    busy_d = (state_d == StArmed);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= StIdle;
      step_q    <= '0;
      cycles_q  <= '0;
      match_q   <= '0;
      timer_q   <= '0;
      busy_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      timeout_q <= 1'b0;
      last_q    <= '0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      cycles_q  <= cycles_d;
      match_q   <= match_d;
      timer_q   <= timer_d;
      busy_q    <= busy_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      timeout_q <= timeout_d;
      last_q    <= last_d;
    end
  end

  assign mon_io.busy_o    = busy_q;
  assign mon_io.pass_o    = pass_q;
  assign mon_io.fail_o    = fail_q;
  assign mon_io.timeout_o = timeout_q;
  assign mon_io.step_o    = step_q;
  assign mon_io.cycles_o  = cycles_q;
  assign mon_io.last_o    = last_q;
endmodule
